dm_unit: RTL

DM_UNIT -- requirements
Module: dm_unit

---
 rtl/dm_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/dm_unit.sv
// Data memory for the memory stage: byte-enabled word stores, combinational
// reads and a registered one-cycle trace of every committed store.
module dm_unit #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic [3:0]  Byteen,
    output logic [31:0] RD,
    output logic        addr_err,
    output logic        wr_valid,
    output logic [31:0] wr_pc,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [31:0] wr_cnt
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [31:0]      mem_d [DEPTH_WORDS];
    logic [31:0]      off;
    logic [IDX_W-1:0] idx;
    logic             in_win;
    logic             commit;
    logic [31:0]      old_word;
    logic [31:0]      merged;

    logic             wr_valid_q, wr_valid_d;
    logic [31:0]      wr_pc_q, wr_pc_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;
    logic [31:0]      wr_cnt_q, wr_cnt_d;

    // Addresses below BASE_ADDR would wrap the offset, so reject them first.
    assign off      = Addr - BASE_ADDR;
    assign in_win   = (Addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
    assign idx      = off[IDX_W+1:2];
    assign old_word = mem_q[idx];
    assign addr_err = !in_win;
    assign RD       = in_win ? old_word : 32'h0;
    assign commit   = in_win && (Byteen != 4'b0000);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (Byteen[i]) merged[8*i +: 8] = WD[8*i +: 8];
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (reset) begin
            mem_d = '{default: '0};
        end else if (commit) begin
            mem_d[idx] = merged;
        end
    end

    // Trace fields hold between pulses; only wr_valid drops back to 0.
    always_comb begin
        wr_valid_d = commit;
        wr_pc_d    = wr_pc_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_cnt_d   = wr_cnt_q;
        if (commit) begin
            wr_pc_d   = pc;
            wr_addr_d = {Addr[31:2], 2'b00};
            wr_data_d = merged;
            wr_cnt_d  = wr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_valid_q <= 1'b0;
            wr_pc_q    <= 32'h0;
            wr_addr_q  <= 32'h0;
            wr_data_q  <= 32'h0;
            wr_cnt_q   <= 32'h0;
        end else begin
            wr_valid_q <= wr_valid_d;
            wr_pc_q    <= wr_pc_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_pc    = wr_pc_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_cnt   = wr_cnt_q;

endmodule
